// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and width helpers for the fifo slice.
//   FIFO_DATA_WIDTH / FIFO_DEPTH : default entry width and entry count
//   ptr_t / count_t             : pointer and occupancy types for the defaults
//   fifo_ptr_w()                : pointer width for an arbitrary power-of-two depth
package fifo_pkg;

  localparam int unsigned FIFO_DATA_WIDTH = 8;
  localparam int unsigned FIFO_DEPTH      = 8;

  localparam int unsigned FIFO_PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned FIFO_CNT_W = FIFO_PTR_W + 1;

  typedef logic [FIFO_PTR_W-1:0] ptr_t;
  typedef logic [FIFO_CNT_W-1:0] count_t;

  // Depth 1 would give a zero-width pointer; clamp to one bit.
  function automatic int unsigned fifo_ptr_w(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_if.sv
// fifo_if: producer/consumer handshake bundle for fifo.
//   wren, i_data : write request and data (master -> slave)
//   rden         : read request           (master -> slave)
//   o_data       : registered read data   (slave -> master)
//   full, empty  : occupancy flags        (slave -> master)
//   overflow, underflow : sticky error flags, only with FIFO_ERR_FLAGS_EN
interface fifo_if #(
  parameter int unsigned DATA_WIDTH = 8
);

  logic                  wren;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  rden;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  full;
  logic                  empty;
`ifdef FIFO_ERR_FLAGS_EN
  logic                  overflow;
  logic                  underflow;
`endif

  modport master (
    output wren, i_data, rden,
`ifdef FIFO_ERR_FLAGS_EN
    input  overflow, underflow,
`endif
    input  o_data, full, empty
  );

  modport slave (
    input  wren, i_data, rden,
`ifdef FIFO_ERR_FLAGS_EN
    output overflow, underflow,
`endif
    output o_data, full, empty
  );

endinterface

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x DATA_WIDTH register array for fifo.
//   clk, rst_n : clock, synchronous active-low reset (clears rdata only)
//   we, waddr, wdata : synchronous write port
//   re, raddr, rdata : synchronous read port, rdata registered and held
//                      between reads
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int unsigned DEPTH      = FIFO_DEPTH,
  localparam int unsigned ADDR_W    = fifo_ptr_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage is deliberately not reset; a write on a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (rst_n && we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/fifo.sv
// fifo: synchronous single-clock FIFO, DEPTH entries x DATA_WIDTH bits.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : fifo_if.slave (wren, i_data, rden, o_data, full, empty)
// Optional macro FIFO_ERR_FLAGS_EN adds sticky overflow/underflow outputs
// on bus. DEPTH must be a power of two >= 2; bus must be built with the
// same DATA_WIDTH.
module fifo
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int unsigned DEPTH      = FIFO_DEPTH
) (
  input  logic   clk,
  input  logic   rst_n,
  fifo_if.slave  bus
);

  localparam int unsigned PTR_W = fifo_ptr_w(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             wr_acc;
  logic             rd_acc;
  logic             full_q;
  logic             empty_q;

  // Flags decode the registered count only, so no input reaches them
  // combinationally; acceptance uses those same flags.
  always_comb begin
    full_q  = (count == CNT_W'(DEPTH));
    empty_q = (count == '0);
    wr_acc  = bus.wren & ~full_q;
    rd_acc  = bus.rden & ~empty_q;
  end

  assign bus.full  = full_q;
  assign bus.empty = empty_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (bus.i_data),
    .re    (rd_acc),
    .raddr (rd_ptr),
    .rdata (bus.o_data)
  );

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q;
  logic underflow_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.wren && full_q) begin
        overflow_q <= 1'b1;
      end
      if (bus.rden && empty_q) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo.sv
module tb_fifo;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_if #(.DATA_WIDTH(8)) bus ();

  fifo #(
    .DATA_WIDTH (8),
    .DEPTH      (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural model: a queue of bytes plus the last popped value.
  logic [7:0] m_q[$];
  logic [7:0] m_out = 8'h00;
  bit         m_ovf = 1'b0;
  bit         m_unf = 1'b0;
  int         m_sz;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_q.delete();
      m_out = 8'h00;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      m_sz = m_q.size();
      if (bus.wren && m_sz == 8) m_ovf = 1'b1;
      if (bus.rden && m_sz == 0) m_unf = 1'b1;
      if (bus.rden && m_sz != 0) m_out = m_q.pop_front();
      if (bus.wren && m_sz != 8) m_q.push_back(bus.i_data);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every meaningful output against the model.
  task automatic compare_model();
    chk("model_empty", 32'(bus.empty), 32'(m_q.size() == 0));
    chk("model_full", 32'(bus.full), 32'(m_q.size() == 8));
    chk("model_o_data", 32'(bus.o_data), 32'(m_out));
`ifdef FIFO_ERR_FLAGS_EN
    chk("model_overflow", 32'(bus.overflow), 32'(m_ovf));
    chk("model_underflow", 32'(bus.underflow), 32'(m_unf));
`endif
  endtask

  // Drive at a falling edge, let one rising edge happen, then compare.
  task automatic step(input bit w, input logic [7:0] d, input bit r);
    bus.wren   = w;
    bus.i_data = d;
    bus.rden   = r;
    @(negedge clk);
    if (chk_en) compare_model();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] v;
    bus.wren   = 1'b0;
    bus.rden   = 1'b0;
    bus.i_data = 8'h00;
    @(negedge clk);

    // Reset
    rst_n  = 1'b0;
    chk_en = 1'b1;
    step(0, 8'h00, 0);
    rst_n = 1'b1;
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_o_data", 32'(bus.o_data), 32'h00);

    // Fill
    for (int i = 0; i < 8; i++) begin
      v = 8'h01 << i;
      step(1, v, 0);
      chk("fill_full", 32'(bus.full), 32'(i == 7));
      chk("fill_empty", 32'(bus.empty), 32'd0);
    end
    step(1, 8'hFF, 0);
    chk("overfill_full", 32'(bus.full), 32'd1);
`ifdef FIFO_ERR_FLAGS_EN
    chk("overflow_set", 32'(bus.overflow), 32'd1);
`endif

    // Drain: the rejected 8'hFF must not appear
    for (int i = 0; i < 8; i++) begin
      step(0, 8'h00, 1);
      v = 8'h01 << i;
      chk("drain_o_data", 32'(bus.o_data), 32'(v));
      chk("drain_empty", 32'(bus.empty), 32'(i == 7));
    end
    step(0, 8'h00, 1);
    chk("underread_o_data", 32'(bus.o_data), 32'h80);
`ifdef FIFO_ERR_FLAGS_EN
    chk("underflow_set", 32'(bus.underflow), 32'd1);
`endif

    // Wrap-around: offset pointers by 5, then a full pass
    for (int i = 0; i < 5; i++) step(1, 8'h10 + 8'(i), 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 8'h00, 1);
      chk("wrap_pre_o_data", 32'(bus.o_data), 32'h10 + 32'(i));
    end
    chk("wrap_pre_empty", 32'(bus.empty), 32'd1);
    for (int i = 0; i < 8; i++) step(1, 8'hA0 + 8'(i), 0);
    chk("wrap_full", 32'(bus.full), 32'd1);
    for (int i = 0; i < 8; i++) begin
      step(0, 8'h00, 1);
      chk("wrap_o_data", 32'(bus.o_data), 32'hA0 + 32'(i));
      chk("wrap_full_after_read", 32'(bus.full), 32'd0);
    end
    chk("wrap_empty", 32'(bus.empty), 32'd1);

    // Simultaneous read/write with 3 queued
    for (int i = 0; i < 3; i++) step(1, 8'hB0 + 8'(i), 0);
    step(1, 8'hC0, 1);
    chk("sim_o_data0", 32'(bus.o_data), 32'hB0);
    step(1, 8'hC1, 1);
    chk("sim_o_data1", 32'(bus.o_data), 32'hB1);
    step(1, 8'hC2, 1);
    chk("sim_o_data2", 32'(bus.o_data), 32'hB2);
    step(1, 8'hC3, 1);
    chk("sim_o_data3", 32'(bus.o_data), 32'hC0);
    chk("sim_empty", 32'(bus.empty), 32'd0);
    for (int i = 1; i < 4; i++) begin
      step(0, 8'h00, 1);
      chk("sim_tail_o_data", 32'(bus.o_data), 32'hC0 + 32'(i));
    end
    chk("sim_tail_empty", 32'(bus.empty), 32'd1);

    // Simultaneous on empty: write accepted, no bypass
    step(1, 8'hD0, 1);
    chk("sim_empty_o_data", 32'(bus.o_data), 32'hC3);
    chk("sim_empty_empty", 32'(bus.empty), 32'd0);
    step(0, 8'h00, 1);
    chk("sim_empty_read", 32'(bus.o_data), 32'hD0);

    // Mid-operation reset with a concurrent write
    for (int i = 0; i < 6; i++) step(1, 8'hE0 + 8'(i), 0);
    rst_n = 1'b0;
    step(1, 8'hEE, 0);
    rst_n = 1'b1;
    chk("mid_rst_empty", 32'(bus.empty), 32'd1);
    chk("mid_rst_full", 32'(bus.full), 32'd0);
    chk("mid_rst_o_data", 32'(bus.o_data), 32'h00);
`ifdef FIFO_ERR_FLAGS_EN
    chk("mid_rst_overflow", 32'(bus.overflow), 32'd0);
    chk("mid_rst_underflow", 32'(bus.underflow), 32'd0);
`endif
    step(0, 8'h00, 1);
    chk("mid_rst_discard_o_data", 32'(bus.o_data), 32'h00);
    chk("mid_rst_discard_empty", 32'(bus.empty), 32'd1);
    step(1, 8'h5A, 0);
    step(0, 8'h00, 1);
    chk("post_rst_o_data", 32'(bus.o_data), 32'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
